// File: rtl/mux_rr_arbiter_pkg.sv
// Shared constants and state encoding for the round-robin 8:1 mux arbiter.
// The optional hold limit is enabled with MUX_ARB_HOLD_LIMIT_EN.
package mux_rr_arbiter_pkg;
  localparam int N                = 8;
  localparam int SELW             = 3;
  localparam int MAX_HOLD_DEFAULT = 15;

  typedef enum logic {
    IDLE  = 1'b0,
    GRANT = 1'b1
  } state_e;
endpackage

// File: rtl/rr_priority_pick.sv
// Combinational rotating priority picker: finds the first set request
// scanning start, start+1, ... with indices wrapping mod N.
module rr_priority_pick
  import mux_rr_arbiter_pkg::*;
(
  input  logic [N-1:0]    req,
  input  logic [SELW-1:0] start,
  output logic            found,
  output logic [SELW-1:0] idx,
  output logic [N-1:0]    onehot
);

  logic [SELW-1:0] j;

  // Scan from the far end back so the closest hit to start is written last.
  always_comb begin
    found = 1'b0;
    idx   = '0;
    j     = '0;
    for (int k = N - 1; k >= 0; k--) begin
      j = start + SELW'(k);
      if (req[j]) begin
        found = 1'b1;
        idx   = j;
      end
    end
  end

  assign onehot = found ? (N'(1) << idx) : '0;

endmodule

// File: rtl/mux_rr_arbiter.sv
// Round-robin ownership controller for an 8:1 single-bit mux.
// Define MUX_ARB_HOLD_LIMIT_EN to force rotation after MAX_HOLD grant cycles.
module mux_rr_arbiter
  import mux_rr_arbiter_pkg::*;
#(
  parameter int MAX_HOLD = MAX_HOLD_DEFAULT
) (
  input  logic            clk,
  input  logic            rst,
  input  logic [N-1:0]    req,
  input  logic [N-1:0]    I,
  output logic [N-1:0]    gnt,
  output logic [SELW-1:0] s,
  output logic            valid,
  output logic            Y
);

  state_e          state_q;
  logic [SELW-1:0] ptr_q;
  logic [N-1:0]    gnt_q;
  logic [SELW-1:0] s_q;
  logic            valid_q;

  logic            timeout_w;
  logic            release_w;
  logic [SELW-1:0] pick_start;
  logic            pick_found;
  logic [SELW-1:0] pick_idx;
  logic [N-1:0]    pick_onehot;

`ifdef MUX_ARB_HOLD_LIMIT_EN
  logic [7:0] hold_cnt_q;

  assign timeout_w = req[s_q] && (hold_cnt_q == 8'(MAX_HOLD - 1));

  always_ff @(posedge clk) begin
    if (rst) begin
      hold_cnt_q <= '0;
    end else if (state_q == IDLE || release_w) begin
      hold_cnt_q <= '0;
    end else begin
      hold_cnt_q <= hold_cnt_q + 8'd1;
    end
  end
`else
  logic [7:0] unused_max_hold;

  assign unused_max_hold = 8'(MAX_HOLD);
  assign timeout_w       = 1'b0;
`endif

  assign release_w = (state_q == GRANT) && (!req[s_q] || timeout_w);

  // Starting after the owner puts a timed-out owner last in the scan.
  assign pick_start = (state_q == GRANT) ? s_q + SELW'(1) : ptr_q;

  rr_priority_pick u_pick (
    .req    (req),
    .start  (pick_start),
    .found  (pick_found),
    .idx    (pick_idx),
    .onehot (pick_onehot)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      ptr_q   <= '0;
      gnt_q   <= '0;
      s_q     <= '0;
      valid_q <= 1'b0;
    end else begin
      case (state_q)
        IDLE: begin
          if (pick_found) begin
            gnt_q   <= pick_onehot;
            s_q     <= pick_idx;
            valid_q <= 1'b1;
            state_q <= GRANT;
          end
        end
        GRANT: begin
          if (release_w) begin
            ptr_q <= s_q + SELW'(1);
            if (pick_found) begin
              gnt_q <= pick_onehot;
              s_q   <= pick_idx;
            end else begin
              gnt_q   <= '0;
              s_q     <= '0;
              valid_q <= 1'b0;
              state_q <= IDLE;
            end
          end
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  assign gnt   = gnt_q;
  assign s     = s_q;
  assign valid = valid_q;
  assign Y     = valid_q ? I[s_q] : 1'b0;

endmodule

// File: doc/mux_rr_arbiter.md
# mux_rr_arbiter

Round-robin arbiter that shares the 8:1 single-bit mux datapath among eight requesters. It turns a request vector into a registered one-hot grant plus the matching 3-bit mux select, and presents the granted requester's data bit as the output. It sits in front of the 8:1 mux as its sequencing and ownership controller. An optional hold limit forces rotation so that no requester can monopolise the mux.

## Interface
- `N` — default 8 — requester count; fixed to the 8:1 mux width, not a free parameter.
- `SELW` — default 3 — select width, log2(N).
- `MAX_HOLD` — default 15 — maximum consecutive grant cycles; range 1..255. Used only when the hold limit is compiled in.
- `clk` — in — 1 — single clock; all state updates on the rising edge.
- `rst` — in — 1 — synchronous reset, active-high.
- `req` — in — 8 — per-requester request; level-sensitive, held high for as long as the requester wants the mux.
- `I` — in — 8 — per-requester data bits; these are the mux data inputs.
- `gnt` — out — 8 — registered one-hot grant; all zeros when idle.
- `s` — out — 3 — registered mux select; equals the index of the set `gnt` bit.
- `valid` — out — 1 — registered; high while a grant is active.
- `Y` — out — 1 — `I[s]` when `valid` is high, otherwise 0. Combinational from `I`, `s` and `valid`.

## Operation
- State machine states:
  - `IDLE`: no grant outstanding.
  - `GRANT`: one requester owns the mux.
- Internal state:
  - `ptr` (3 bits): highest-priority index for the next arbitration.
  - `hold_cnt` (8 bits): counts cycles of the current grant.
- Arbitration (combinational): the winner is the first set bit of `req` scanning `ptr`, `ptr+1`, … `ptr+7`, with indices wrapping mod 8.
- `IDLE`, `req == 0`: stay in `IDLE`.
- `IDLE`, `req != 0`: register `gnt`/`s` for the winner, set `valid = 1`, clear `hold_cnt`, go to `GRANT`.
- `GRANT`, `req[s]` still high and no timeout: hold `gnt`/`s`, increment `hold_cnt`.
- Release occurs when `req[s]` is sampled low, or on timeout.
- On release:
  - Set `ptr = s + 1` (mod 8).
  - Re-arbitrate in the same cycle starting from `s + 1`.
  - If any request is pending, grant the new winner on the same edge. There is no idle cycle, `hold_cnt` clears, and the state stays `GRANT`.
  - Otherwise clear `gnt`, set `valid = 0`, `s = 0`, and go to `IDLE`.
- Timeout: `req[s]` is high and `hold_cnt == MAX_HOLD - 1`.
  - The current owner has last priority at re-arbitration.
  - It is re-granted, with `hold_cnt` cleared, only if no other request is pending.
- `req` bits for non-granted indices never disturb an active grant.
- `s` wraps from 7 to 0 in the pointer arithmetic. All index arithmetic is 3-bit unsigned mod 8.

## Timing
- Reset values: `gnt = 8'b0`, `s = 3'b000`, `valid = 0`, `Y = 0`, `ptr = 0`, `hold_cnt = 0`, state `IDLE`.
- Reset dominates every other event in the same cycle. Reset applied mid-grant drops the grant at that edge.
- Grant latency:
  - `req` first sampled high at edge k gives `gnt`/`s`/`valid` at edge k.
  - These outputs are visible in the cycle after edge k; that is, one cycle of latency from `req` to `gnt`.
- Release latency: `req[s]` sampled low at edge k means `gnt` changes at edge k.
- Handover: the new owner's `gnt` is asserted on the same edge the old one is removed. `gnt` is never two-hot and never has a gap while requests are pending.
- Timeout: with the limit compiled in, a continuously requesting owner holds exactly `MAX_HOLD` cycles.
- Simultaneous release and new request at the same edge: the new request takes part in that edge's arbitration.
- `Y` follows `I[s]` combinationally, with zero cycles of latency from `I`.

## Configuration
- Macro: `MUX_ARB_HOLD_LIMIT_EN`.
- Defined:
  - `hold_cnt` and the timeout release are implemented.
  - A continuous requester is rotated out after `MAX_HOLD` cycles whenever another request is pending.
- Undefined:
  - No counter logic is generated.
  - Release happens only when `req[s]` drops.
  - A continuous requester holds the mux indefinitely.
  - `MAX_HOLD` is ignored.

## Structure
- Shared package/include holds:
  - Constants `N` and `SELW`.
  - State encoding: `IDLE = 1'b0`, `GRANT = 1'b1`.
  - Default `MAX_HOLD`.
- One sub-module, `rr_priority_pick`. It is combinational: inputs are `req[7:0]` and `start[2:0]`; outputs are `found`, `idx[2:0]` and `onehot[7:0]`. It is used both for the `IDLE` grant and for release re-arbitration.
- The top level contains the state register, `ptr`, `hold_cnt`, output registers and the `Y` select.

## Test plan
- Reset check: assert `rst` for 2 cycles with `req = 8'hFF` → `gnt = 0`, `valid = 0`, `s = 0`, `Y = 0` throughout. The first grant after reset goes to index 0.
- Single requester: `req = 8'b0000_1000`, `I = 8'b1010_1101` → next cycle `gnt = 8'b0000_1000`, `s = 3`, `Y = 1`. Dropping `req` returns to `IDLE` with `gnt = 0`, `Y = 0`.
- Rotation:
  - Start with `req = 8'hFF` and each owner dropping its request for one cycle after one grant cycle.
  - Required grant sequence: `s` = 0, 1, 2, … 7, 0, with no idle cycles.
  - `Y` must match bits of `I = 8'b1010_1101`: 1, 0, 1, 1, 0, 1, 0, 1.
- Wrap-around priority: owner `s = 6` releases while `req = 8'b0100_0011` → next `s = 0`, and index 6 is skipped.
- Hold limit (`MUX_ARB_HOLD_LIMIT_EN`, `MAX_HOLD = 4`):
  - `req = 8'b0000_0101` held constant.
  - Required grants: `s = 0` for 4 cycles, then `s = 2` for 4 cycles, alternating.
  - Without the macro, `s = 0` forever.
- Mid-grant reset: with `gnt = 8'b0010_0000`, assert `rst` for 1 cycle → `gnt = 0` at that edge, then `ptr = 0` and re-arbitration from index 0.
